pacman_move_ctrl: RTL and testbench
===================================

Name: pacman_move_ctrl

Overview:
- Movement controller directly downstream of the background-ROM wall probe.
- On each game move tick, asks the probe to check the four neighbours of Pac-Man's current position, then consumes the returned blocked flags.
- Applies the buffered player turn or continues in the current direction, then updates the sprite position used by the draw and probe stages.

Parameters:
- START_X, 51, reset x position (pixel column, 320-wide screen)
- START_Y, 3, reset y position (pixel row)
- X_MAX, 319, largest legal x; smallest legal x is 0
- Y_MAX, 239, largest legal y; smallest legal y is 0
- WRAP_EN, 1, 1 = horizontal tunnel wrap; 0 = clamp at edges
- PROBE_TIMEOUT, 16, cycles to wait for probe_done before forcing all-blocked

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- resetn  in  1  asynchronous active-low reset
- move_tick  in  1  single-cycle pulse; one move attempt per pulse
- key_n  in  4  active-low direction buttons: [3] left, [2] right, [1] up, [0] down
- probe_start  out  1  single-cycle pulse requesting a neighbour check
- probe_x  out  9  x to probe, valid while busy
- probe_y  out  9  y to probe, valid while busy
- probe_done  in  1  single-cycle pulse; walls_blocked is valid in the same cycle
- walls_blocked  in  4  1 = wall at neighbour: [3] left, [2] right, [1] up, [0] down
- pac_x  out  9  current x
- pac_y  out  9  current y
- cur_dir  out  4  one-hot current heading (same bit order as key_n); 0 = stationary
- moved  out  1  one-cycle pulse when pac_x or pac_y changed
- busy  out  1  high from probe_start until the decision has been applied
- tick_missed  out  1  sticky; set when move_tick arrives while busy
- probe_err  out  1  one-cycle pulse on probe timeout

Behaviour:
- Reset (async, resetn=0):
  - pac_x=START_X, pac_y=START_Y
  - cur_dir=0, desired_dir=0
  - State IDLE
  - All pulse outputs, busy and tick_missed = 0
  - probe_x/probe_y = START_X/START_Y
- Turn buffer, every cycle in any state:
  - Any key_n bit low latches desired_dir (one-hot).
  - Priority when several keys are low: left > right > up > down.
  - desired_dir holds after release until consumed.
- FSM states: IDLE, REQ, WAIT, APPLY.
- IDLE:
  - On move_tick: probe_x<=pac_x, probe_y<=pac_y; go to REQ.
- REQ:
  - probe_start=1 for exactly this cycle; busy=1.
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - On probe_done: latch walls_blocked; go to APPLY.
  - If the counter reaches PROBE_TIMEOUT without probe_done: treat as walls=4'b1111, pulse probe_err, go to APPLY.
  - A probe_done in the same cycle as the timeout wins; no error.
- APPLY (one cycle), then IDLE:
  - If desired_dir!=0 and its wall bit is 0: cur_dir<=desired_dir, desired_dir<=0, step in that direction.
  - Else if cur_dir!=0 and its wall bit is 0: step in cur_dir; desired_dir is kept for a later tick.
  - Else: no step; cur_dir<=0 if it was blocked; desired_dir is kept.
- Step arithmetic (1 pixel):
  - Left: x-1. At x=0: x=X_MAX if WRAP_EN, else no step.
  - Right: x+1. At x=X_MAX: x=0 if WRAP_EN, else no step.
  - Up: y-1. At y=0: no step.
  - Down: y+1. At y=Y_MAX: no step.
  - Vertical movement never wraps.
- moved:
  - Pulses in the cycle after APPLY, only when the position changed.
  - A blocked or clamped move gives no pulse.
- busy and tick_missed:
  - busy is high in REQ, WAIT and APPLY.
  - move_tick while busy is dropped and sets tick_missed, which clears only on reset.
- Timing:
  - Latency from move_tick to updated pac_x/pac_y = 3 cycles + probe latency.
  - probe_x/probe_y stay stable from REQ through APPLY.
- Reset asserted mid-operation aborts immediately. No probe_start is issued until the next move_tick after release.
- probe_done outside WAIT is ignored.

Test Plan:
- Reset, key_n=4'b1111, one move_tick, probe returns walls=0 -> position stays (51,3), cur_dir=0, moved never pulses, probe_start pulsed exactly once.
- key_n[2] low 1 cycle, move_tick, walls=4'b0000 -> cur_dir=4'b0100, pac_x=52; second tick with key_n released -> pac_x=53.
- From (52,3) heading right: press up, tick with walls=4'b0010 -> up refused, pac_x=53, desired kept; next tick walls=0 -> pac_y=2, cur_dir=4'b0010.
- pac_x=0, heading left, walls=0: WRAP_EN=1 -> pac_x=319, moved=1; WRAP_EN=0 -> pac_x=0, moved=0.
- probe_done held low -> probe_err pulses exactly PROBE_TIMEOUT cycles after leaving REQ, no movement, cur_dir becomes 0, FSM back in IDLE.
- Second move_tick during WAIT -> tick_missed=1 and only one probe_start; resetn low during WAIT -> outputs return to reset values at once, no probe_start after release until a new tick.

Source files
------------

// File: rtl/pacman_move_ctrl.sv
// Pac-Man movement controller: probes the four neighbours on every move tick,
// then applies the buffered turn or keeps the heading, stepping one pixel.
module pacman_move_ctrl #(
  parameter int START_X       = 51,
  parameter int START_Y       = 3,
  parameter int X_MAX         = 319,
  parameter int Y_MAX         = 239,
  parameter bit WRAP_EN       = 1'b1,
  parameter int PROBE_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       move_tick,
  input  logic [3:0] key_n,
  output logic       probe_start,
  output logic [8:0] probe_x,
  output logic [8:0] probe_y,
  input  logic       probe_done,
  input  logic [3:0] walls_blocked,
  output logic [8:0] pac_x,
  output logic [8:0] pac_y,
  output logic [3:0] cur_dir,
  output logic       moved,
  output logic       busy,
  output logic       tick_missed,
  output logic       probe_err
);

  localparam int CW = $clog2(PROBE_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, APPLY} state_t;

  state_t          state_q, state_d;
  logic [8:0]      pac_x_q, pac_x_d, pac_y_q, pac_y_d;
  logic [8:0]      probe_x_q, probe_x_d, probe_y_q, probe_y_d;
  logic [3:0]      cur_dir_q, cur_dir_d, desired_q, desired_d;
  logic [3:0]      walls_q, walls_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            moved_q, moved_d, tick_missed_q, tick_missed_d;

  logic [3:0]      key_dir, move_dir;
  logic            take_des, take_cur, timeout;
  logic [8:0]      nx, ny;

  // A probe_done arriving in the timeout cycle takes precedence.
  assign timeout = (state_q == WAIT) && (cnt_q == CW'(PROBE_TIMEOUT)) && !probe_done;

  always_comb begin
    key_dir = 4'b0000;
    if      (!key_n[3]) key_dir = 4'b1000;
    else if (!key_n[2]) key_dir = 4'b0100;
    else if (!key_n[1]) key_dir = 4'b0010;
    else if (!key_n[0]) key_dir = 4'b0001;
  end

  assign take_des = (desired_q != 4'b0000) && ((desired_q & walls_q) == 4'b0000);
  assign take_cur = !take_des && (cur_dir_q != 4'b0000) && ((cur_dir_q & walls_q) == 4'b0000);
  assign move_dir = take_des ? desired_q : (take_cur ? cur_dir_q : 4'b0000);

  // Edge handling: horizontal may wrap through the tunnel, vertical always clamps.
  always_comb begin
    nx = pac_x_q;
    ny = pac_y_q;
    if (move_dir[3]) begin
      if (pac_x_q != 9'd0)  nx = pac_x_q - 9'd1;
      else if (WARP_OK())   nx = 9'(X_MAX);
    end else if (move_dir[2]) begin
      if (pac_x_q != 9'(X_MAX)) nx = pac_x_q + 9'd1;
      else if (WARP_OK())       nx = 9'd0;
    end else if (move_dir[1]) begin
      if (pac_y_q != 9'd0) ny = pac_y_q - 9'd1;
    end else if (move_dir[0]) begin
      if (pac_y_q != 9'(Y_MAX)) ny = pac_y_q + 9'd1;
    end
  end

  function automatic logic WARP_OK();
    return WRAP_EN;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (move_tick) state_d = REQ;
      REQ:     state_d = WAIT;
      WAIT:    if (probe_done || timeout) state_d = APPLY;
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    probe_start = (state_q == REQ);
    busy        = (state_q != IDLE);
    probe_err   = timeout;
  end

  always_comb begin
    pac_x_d       = pac_x_q;
    pac_y_d       = pac_y_q;
    probe_x_d     = probe_x_q;
    probe_y_d     = probe_y_q;
    cur_dir_d     = cur_dir_q;
    desired_d     = desired_q;
    walls_d       = walls_q;
    cnt_d         = cnt_q;
    moved_d       = 1'b0;
    tick_missed_d = tick_missed_q | (move_tick && (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (move_tick) begin
          probe_x_d = pac_x_q;
          probe_y_d = pac_y_q;
        end
      end
      REQ: cnt_d = '0;
      WAIT: begin
        if (probe_done)   walls_d = walls_blocked;
        else if (timeout) walls_d = 4'b1111;
        else              cnt_d   = cnt_q + CW'(1);
      end
      APPLY: begin
        pac_x_d = nx;
        pac_y_d = ny;
        moved_d = (nx != pac_x_q) || (ny != pac_y_q);
        if (take_des) begin
          cur_dir_d = desired_q;
          desired_d = 4'b0000;
        end else if (!take_cur) begin
          cur_dir_d = 4'b0000;
        end
      end
      default: ;
    endcase
    // A key held during APPLY re-arms the turn buffer after consumption.
    if (key_dir != 4'b0000) desired_d = key_dir;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pac_x_q       <= 9'(START_X);
      pac_y_q       <= 9'(START_Y);
      probe_x_q     <= 9'(START_X);
      probe_y_q     <= 9'(START_Y);
      cur_dir_q     <= 4'b0000;
      desired_q     <= 4'b0000;
      walls_q       <= 4'b0000;
      cnt_q         <= '0;
      moved_q       <= 1'b0;
      tick_missed_q <= 1'b0;
    end else begin
      pac_x_q       <= pac_x_d;
      pac_y_q       <= pac_y_d;
      probe_x_q     <= probe_x_d;
      probe_y_q     <= probe_y_d;
      cur_dir_q     <= cur_dir_d;
      desired_q     <= desired_d;
      walls_q       <= walls_d;
      cnt_q         <= cnt_d;
      moved_q       <= moved_d;
      tick_missed_q <= tick_missed_d;
    end
  end

  assign pac_x       = pac_x_q;
  assign pac_y       = pac_y_q;
  assign probe_x     = probe_x_q;
  assign probe_y     = probe_y_q;
  assign cur_dir     = cur_dir_q;
  assign moved       = moved_q;
  assign tick_missed = tick_missed_q;

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// Directed bench for pacman_move_ctrl: a wrapping instance (A) is scoreboarded
// per move; a clamping twin (B, starts at x=0) runs in lockstep on the same inputs.
module tb_pacman_move_ctrl;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       resetn, move_tick, probe_done;
  logic [3:0] key_n, walls_blocked;
  logic       probe_start, moved, busy, tick_missed, probe_err;
  logic [8:0] probe_x, probe_y, pac_x, pac_y;
  logic [3:0] cur_dir;
  logic       b_probe_start, b_moved, b_busy, b_tick_missed, b_probe_err;
  logic [8:0] b_probe_x, b_probe_y, b_pac_x, b_pac_y;
  logic [3:0] b_cur_dir;

  pacman_move_ctrl #(.PROBE_TIMEOUT(TO)) u_a (
    .clk(clk), .resetn(resetn), .move_tick(move_tick), .key_n(key_n),
    .probe_start(probe_start), .probe_x(probe_x), .probe_y(probe_y),
    .probe_done(probe_done), .walls_blocked(walls_blocked),
    .pac_x(pac_x), .pac_y(pac_y), .cur_dir(cur_dir), .moved(moved),
    .busy(busy), .tick_missed(tick_missed), .probe_err(probe_err));

  pacman_move_ctrl #(.START_X(0), .WRAP_EN(1'b0), .PROBE_TIMEOUT(TO)) u_b (
    .clk(clk), .resetn(resetn), .move_tick(move_tick), .key_n(key_n),
    .probe_start(b_probe_start), .probe_x(b_probe_x), .probe_y(b_probe_y),
    .probe_done(probe_done), .walls_blocked(walls_blocked),
    .pac_x(b_pac_x), .pac_y(b_pac_y), .cur_dir(b_cur_dir), .moved(b_moved),
    .busy(b_busy), .tick_missed(b_tick_missed), .probe_err(b_probe_err));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int start_cnt = 0, err_cnt = 0, moved_cnt = 0;

  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
    logic [3:0] d;
    logic       m;
  } exp_t;
  exp_t sb[$];
  logic [8:0] prev_x, prev_y;

  always @(posedge clk) begin
    if (resetn) begin
      if (probe_start) start_cnt++;
      if (probe_err)   err_cnt++;
      if (moved)       moved_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk); key_n = k;
    @(negedge clk); key_n = 4'hF;
  endtask

  // delay: negedges after the probe_start cycle at which probe_done is driven; 0 = never.
  task automatic do_move(input logic [3:0] walls, input int delay, input bit extra,
                         input logic [8:0] ex, input logic [8:0] ey,
                         input logic [3:0] ed, input logic em, input bit exp_err);
    exp_t e;
    int   s0, e0, m0, err_n;
    bit   done;
    sb.push_back('{x: ex, y: ey, d: ed, m: em});
    err_n = -1;
    done  = 1'b0;
    @(negedge clk); move_tick = 1'b1;
    s0 = start_cnt; e0 = err_cnt; m0 = moved_cnt;
    @(negedge clk); move_tick = 1'b0; #1;
    chk("probe_start", 32'(probe_start), 32'd1);
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clk);
      probe_done    = (k == delay);
      walls_blocked = walls;
      move_tick     = extra && (k == 1);
      #1;
      if (k == 1) begin
        chk("probe_x", 32'(probe_x), 32'(prev_x));
        chk("probe_y", 32'(probe_y), 32'(prev_y));
        chk("busy_wait", 32'(busy), 32'd1);
      end
      if (probe_err) err_n = k;
      if (!busy) done = 1'b1;
    end
    probe_done = 1'b0;
    move_tick  = 1'b0;
    chk("op_done", 32'(done), 32'd1);
    e = sb.pop_front();
    chk("pac_x", 32'(pac_x), 32'(e.x));
    chk("pac_y", 32'(pac_y), 32'(e.y));
    chk("cur_dir", 32'(cur_dir), 32'(e.d));
    chk("moved", 32'(moved), 32'(e.m));
    chk("moved_stray", 32'(moved_cnt - m0), 32'd0);
    chk("start_count", 32'(start_cnt - s0), 32'd1);
    chk("err_count", 32'(err_cnt - e0), 32'(exp_err));
    // REQ->WAIT edge happens one negedge after probe_start; error shows TO cycles later.
    if (exp_err) chk("err_at", 32'(err_n), 32'(TO + 1));
    prev_x = e.x;
    prev_y = e.y;
  endtask

  initial begin
    int s0, m0;
    resetn = 1'b0; move_tick = 1'b0; probe_done = 1'b0;
    key_n = 4'hF; walls_blocked = 4'h0;
    prev_x = 9'd51; prev_y = 9'd3;
    #12;
    chk("rst_pac_x", 32'(pac_x), 32'd51);
    chk("rst_pac_y", 32'(pac_y), 32'd3);
    chk("rst_cur_dir", 32'(cur_dir), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tick_missed", 32'(tick_missed), 32'd0);
    chk("rst_probe_x", 32'(probe_x), 32'd51);
    chk("rst_probe_y", 32'(probe_y), 32'd3);
    chk("rst_moved", 32'(moved), 32'd0);
    chk("rst_b_pac_x", 32'(b_pac_x), 32'd0);
    @(negedge clk); resetn = 1'b1;

    // No key, open walls: nothing moves.
    do_move(4'h0, 1, 1'b0, 9'd51, 9'd3, 4'b0000, 1'b0, 1'b0);
    // Right press, probe_done lands in the timeout cycle: done wins.
    press(4'b1011);
    do_move(4'h0, TO + 1, 1'b0, 9'd52, 9'd3, 4'b0100, 1'b1, 1'b0);
    chk("b_right", 32'(b_pac_x), 32'd1);
    do_move(4'h0, 1, 1'b0, 9'd53, 9'd3, 4'b0100, 1'b1, 1'b0);
    // Up refused by wall: keep going right, turn later.
    press(4'b1101);
    do_move(4'b0010, 2, 1'b0, 9'd54, 9'd3, 4'b0100, 1'b1, 1'b0);
    do_move(4'h0, 1, 1'b0, 9'd54, 9'd2, 4'b0010, 1'b1, 1'b0);
    do_move(4'b0010, 1, 1'b0, 9'd54, 9'd2, 4'b0000, 1'b0, 1'b0);
    // Left buffered through an all-blocked probe.
    press(4'b0111);
    do_move(4'hF, 3, 1'b0, 9'd54, 9'd2, 4'b0000, 1'b0, 1'b0);
    do_move(4'h0, 1, 1'b0, 9'd53, 9'd2, 4'b1000, 1'b1, 1'b0);
    for (int i = 0; i <= 52; i++)
      do_move(4'h0, 1, 1'b0, 9'(52 - i), 9'd2, 4'b1000, 1'b1, 1'b0);
    chk("b_clamp_x", 32'(b_pac_x), 32'd0);
    chk("b_clamp_dir", 32'(b_cur_dir), 32'b1000);
    // Tunnel wrap on A; B stays clamped without a moved pulse.
    do_move(4'h0, 1, 1'b0, 9'd319, 9'd2, 4'b1000, 1'b1, 1'b0);
    chk("b_wrap_moved", 32'(b_moved), 32'd0);
    chk("b_wrap_x", 32'(b_pac_x), 32'd0);
    // Up to the top edge, then clamp.
    press(4'b1101);
    do_move(4'h0, 1, 1'b0, 9'd319, 9'd1, 4'b0010, 1'b1, 1'b0);
    do_move(4'h0, 1, 1'b0, 9'd319, 9'd0, 4'b0010, 1'b1, 1'b0);
    do_move(4'h0, 1, 1'b0, 9'd319, 9'd0, 4'b0010, 1'b0, 1'b0);
    // Probe never answers: forced all-blocked stops the heading.
    do_move(4'h0, 0, 1'b0, 9'd319, 9'd0, 4'b0000, 1'b0, 1'b1);
    chk("idle_after_timeout", 32'(busy), 32'd0);
    // Extra tick while busy is dropped and flagged.
    do_move(4'h0, 3, 1'b1, 9'd319, 9'd0, 4'b0000, 1'b0, 1'b0);
    chk("tick_missed", 32'(tick_missed), 32'd1);

    // Reset in WAIT aborts at once; stray probe_done in IDLE is ignored.
    @(negedge clk); move_tick = 1'b1;
    @(negedge clk); move_tick = 1'b0;
    @(negedge clk);
    s0 = start_cnt;
    m0 = moved_cnt;
    resetn = 1'b0; #1;
    chk("abort_pac_x", 32'(pac_x), 32'd51);
    chk("abort_pac_y", 32'(pac_y), 32'd3);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_tick_missed", 32'(tick_missed), 32'd0);
    chk("abort_probe_x", 32'(probe_x), 32'd51);
    @(negedge clk); resetn = 1'b1;
    repeat (4) @(negedge clk);
    probe_done = 1'b1; walls_blocked = 4'h0;
    @(negedge clk); probe_done = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("no_restart", 32'(start_cnt - s0), 32'd0);
    chk("idle_ignore_done", 32'(busy), 32'd0);
    chk("idle_no_move", 32'(moved_cnt - m0), 32'd0);
    prev_x = 9'd51; prev_y = 9'd3;
    press(4'b1011);
    do_move(4'h0, 1, 1'b0, 9'd52, 9'd3, 4'b0100, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
